rob_multiport: RTL and testbench

//  Parametrised circular reorder buffer between dispatch, execute writeback and architectural register file.

---
 rtl/rob_multiport.sv | 110 +++++++++++
 tb/tb_rob_multiport.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multiport.sv
// rob_multiport: circular reorder buffer, multi-lane dispatch, multi-port writeback, in-order multi-lane retire.
// Define ROB_FLUSH_EN to add the flush port.
module rob_multiport #(
  parameter int NUM_ENTRIES    = 64,
  parameter int DISPATCH_WIDTH = 2,
  parameter int RETIRE_WIDTH   = 4,
  parameter int WB_PORTS       = 3,
  parameter int DATA_W         = 32,
  parameter int AREG_W         = 5,
  localparam int IDX_W         = $clog2(NUM_ENTRIES)
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef ROB_FLUSH_EN
  input  logic                             flush,
`endif
  input  logic [DISPATCH_WIDTH-1:0]        disp_valid,
  input  logic [DISPATCH_WIDTH*AREG_W-1:0] disp_dst_reg,
  output logic                             disp_ready,
  output logic [DISPATCH_WIDTH*IDX_W-1:0]  disp_idx,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]        wb_idx,
  input  logic [WB_PORTS*DATA_W-1:0]       wb_val,
  output logic [RETIRE_WIDTH-1:0]          ret_valid,
  output logic [RETIRE_WIDTH*AREG_W-1:0]   ret_dst_reg,
  output logic [RETIRE_WIDTH*DATA_W-1:0]   ret_val,
  output logic [IDX_W:0]                   count,
  output logic                             empty,
  output logic                             full
);
  localparam int CW = IDX_W + 1;
  logic [CW-1:0] head, tail, n_disp, k;
  logic [NUM_ENTRIES-1:0] alloc, done;
  logic [AREG_W-1:0] dst [NUM_ENTRIES];
  logic [DATA_W-1:0] val [NUM_ENTRIES];
  logic [RETIRE_WIDTH-1:0] ret_mask;
  logic do_flush, run_d, run_r;
`ifdef ROB_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif
  assign count = tail - head;
  assign empty = count == '0;
  assign full = count == CW'(NUM_ENTRIES);
  assign disp_ready = (CW'(NUM_ENTRIES) - count) >= CW'(DISPATCH_WIDTH);
  for (genvar g = 0; g < DISPATCH_WIDTH; g++) begin : g_idx
    assign disp_idx[g*IDX_W +: IDX_W] = tail[IDX_W-1:0] + IDX_W'(g);
  end
  // Dispatch lanes count as a low-packed prefix; retire stops at the first not-done entry.
  always_comb begin
    n_disp = '0;
    run_d = 1'b1;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      run_d = run_d & disp_valid[i];
      n_disp = n_disp + CW'(run_d);
    end
    k = '0;
    run_r = 1'b1;
    ret_mask = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      run_r = run_r & done[head[IDX_W-1:0] + IDX_W'(i)] & (CW'(i) < count);
      ret_mask[i] = run_r;
      k = k + CW'(run_r);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      alloc <= '0;
      done <= '0;
      ret_valid <= '0;
      ret_dst_reg <= '0;
      ret_val <= '0;
    end else if (do_flush) begin
      head <= '0;
      tail <= '0;
      alloc <= '0;
      done <= '0;
      ret_valid <= '0;
    end else begin
      ret_valid <= ret_mask;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        ret_dst_reg[i*AREG_W +: AREG_W] <= dst[head[IDX_W-1:0] + IDX_W'(i)];
        ret_val[i*DATA_W +: DATA_W] <= val[head[IDX_W-1:0] + IDX_W'(i)];
        if (ret_mask[i]) begin
          alloc[head[IDX_W-1:0] + IDX_W'(i)] <= 1'b0;
          done[head[IDX_W-1:0] + IDX_W'(i)] <= 1'b0;
        end
      end
      head <= head + k;
      if (disp_ready) begin
        for (int i = 0; i < DISPATCH_WIDTH; i++)
          if (CW'(i) < n_disp) begin
            alloc[tail[IDX_W-1:0] + IDX_W'(i)] <= 1'b1;
            done[tail[IDX_W-1:0] + IDX_W'(i)] <= 1'b0;
            dst[tail[IDX_W-1:0] + IDX_W'(i)] <= disp_dst_reg[i*AREG_W +: AREG_W];
          end
        tail <= tail + n_disp;
      end
      // Ascending port order lets the highest port win on a shared index.
      for (int p = 0; p < WB_PORTS; p++)
        if (wb_valid[p] && alloc[wb_idx[p*IDX_W +: IDX_W]] && !done[wb_idx[p*IDX_W +: IDX_W]]) begin
          done[wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
          val[wb_idx[p*IDX_W +: IDX_W]] <= wb_val[p*DATA_W +: DATA_W];
        end
    end
  end
endmodule

// File: tb/tb_rob_multiport.sv
// tb_rob_multiport: directed stimulus with an in-order retirement scoreboard for rob_multiport.
module tb_rob_multiport;
  localparam int AW = 5, IW = 6;
  logic clk = 1'b0, rst;
`ifdef ROB_FLUSH_EN
  logic flush;
`endif
  logic [1:0] disp_valid;
  logic [9:0] disp_dst_reg;
  logic disp_ready;
  logic [11:0] disp_idx;
  logic [2:0] wb_valid;
  logic [17:0] wb_idx;
  logic [95:0] wb_val;
  logic [3:0] ret_valid;
  logic [19:0] ret_dst_reg;
  logic [127:0] ret_val;
  logic [6:0] count;
  logic empty, full;
  typedef struct packed {logic [AW-1:0] d; logic [31:0] v;} exp_t;
  exp_t q[$];
  int total = 0, passed = 0, mt = 0;
  always #5 clk = ~clk;
  rob_multiport dut (
    .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .disp_valid(disp_valid), .disp_dst_reg(disp_dst_reg), .disp_ready(disp_ready), .disp_idx(disp_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_val(wb_val),
    .ret_valid(ret_valid), .ret_dst_reg(ret_dst_reg), .ret_val(ret_val),
    .count(count), .empty(empty), .full(full)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic push(input int d, input int v);
    exp_t e;
    e.d = AW'(d);
    e.v = 32'(v);
    q.push_back(e);
  endtask
  task automatic clr();
    disp_valid = '0;
    wb_valid = '0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
  endtask
  // Advance one edge, then score every committed lane against the queue.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (ret_valid[i]) begin
        if (q.size() == 0) chk("ret_unexpected", 128'(q.size()), 128'd1);
        else begin
          e = q.pop_front();
          chk("sb_dst", ret_dst_reg[i*AW +: AW], e.d);
          chk("sb_val", ret_val[i*32 +: 32], e.v);
        end
      end
    clr();
  endtask
  task automatic disp(input int d0, input int d1);
    disp_valid = 2'b11;
    disp_dst_reg = {AW'(d1), AW'(d0)};
  endtask
  task automatic wbs(input int p, input int idx, input int v);
    wb_valid[p] = 1'b1;
    wb_idx[p*IW +: IW] = IW'(idx);
    wb_val[p*32 +: 32] = 32'(v);
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && count != 0; i++) step();
    chk("drain", count, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    clr();
    disp_dst_reg = '0;
    wb_idx = '0;
    wb_val = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_disp_idx", disp_idx, {6'd1, 6'd0});
    // two entries, completed out of order
    disp(3, 4);
    step();
    mt = 2;
    chk("disp_count", count, 2);
    chk("disp_idx_adv", disp_idx, {6'd3, 6'd2});
    wbs(0, 1, 'hB);
    step();
    chk("ooo_hold", ret_valid, 0);
    wbs(0, 0, 'hA);
    push(3, 'hA);
    push(4, 'hB);
    step();
    chk("wb_latency", ret_valid, 0);
    step();
    chk("pair_ret_valid", ret_valid, 4'b0011);
    chk("pair_ret_val", ret_val[63:0], {32'hB, 32'hA});
    chk("pair_ret_dst", ret_dst_reg[9:0], {5'd4, 5'd3});
    chk("pair_count", count, 0);
    // head blocks a group of four
    disp(5, 6);
    step();
    disp(7, 8);
    step();
    mt = 6;
    wbs(0, 3, 'h13);
    wbs(1, 4, 'h14);
    wbs(2, 5, 'h15);
    step();
    step();
    chk("head_block", ret_valid, 0);
    chk("head_block_count", count, 4);
    wbs(0, 2, 'h12);
    push(5, 'h12);
    push(6, 'h13);
    push(7, 'h14);
    push(8, 'h15);
    step();
    step();
    chk("quad_ret", ret_valid, 4'hF);
    chk("quad_count", count, 0);
    // repeat completion ignored, highest port wins
    disp(9, 10);
    step();
    mt = 8;
    wbs(0, 7, 'h333);
    step();
    wbs(2, 7, 'h444);
    wbs(0, 6, 'h111);
    wbs(1, 6, 'h222);
    push(9, 'h222);
    push(10, 'h333);
    step();
    step();
    chk("prio_ret_valid", ret_valid, 4'b0011);
    chk("prio_ret_val", ret_val[63:0], {32'h333, 32'h222});
    // fill to capacity
    for (int i = 0; i < 32; i++) begin
      disp((2 * i) % 32, (2 * i + 1) % 32);
      step();
    end
    chk("full_count", count, 64);
    chk("full_flag", full, 1);
    chk("full_ready", disp_ready, 0);
    chk("full_disp_idx", disp_idx, {6'd9, 6'd8});
    disp(1, 2);
    step();
    chk("drop_count", count, 64);
    chk("drop_tail", disp_idx, {6'd9, 6'd8});
    for (int i = 0; i < 64; i++) begin
      wbs(i % 3, (8 + i) % 64, 'h1000 + i);
      push(i % 32, 'h1000 + i);
      if (i % 3 == 2 || i == 63) step();
    end
    mt = 72;
    drain();
    chk("drained_empty", empty, 1);
    chk("drained_full", full, 0);
    // walk the tail up to entry 62
    while (mt % 64 != 62) begin
      disp(mt % 32, (mt + 1) % 32);
      step();
      wbs(0, mt % 64, mt);
      wbs(1, (mt + 1) % 64, mt + 1);
      push(mt % 32, mt);
      push((mt + 1) % 32, mt + 1);
      step();
      mt += 2;
    end
    drain();
    chk("wrap_start_idx", disp_idx, {6'd63, 6'd62});
    disp(1, 2);
    step();
    disp(3, 4);
    step();
    mt += 4;
    chk("wrap_count", count, 4);
    wbs(0, 63, 'h63);
    wbs(1, 0, 'h40);
    wbs(2, 1, 'h41);
    step();
    wbs(0, 62, 'h62);
    push(1, 'h62);
    push(2, 'h63);
    push(3, 'h40);
    push(4, 'h41);
    step();
    chk("wrap_wait", ret_valid, 0);
    step();
    chk("wrap_ret", ret_valid, 4'hF);
    chk("wrap_count_after", count, 0);
    chk("wrap_empty", empty, 1);
    chk("wrap_head_idx", disp_idx, {6'd3, 6'd2});
`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 5; i++) begin
      disp(i, i + 1);
      step();
    end
    chk("flush_pre_count", count, 10);
    flush = 1'b1;
    disp(7, 8);
    wbs(0, 2, 'h55);
    step();
    chk("flush_count", count, 0);
    chk("flush_ret", ret_valid, 0);
    chk("flush_idx", disp_idx, {6'd1, 6'd0});
    chk("flush_empty", empty, 1);
    step();
    chk("flush_quiet", ret_valid, 0);
`endif
    chk("sb_leftover", 128'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
